// File: rtl/scl_generate.sv
// rtl/scl_generate.sv - I2C master SCL bit-timing engine: SCL drive, bit/byte counters, phase strobes.
// Optional SCL_STRETCH_EN: synchronise the SCL pin and hold the high phase until the line is seen high.
module scl_generate #(
  parameter int ADDR_LEN        = 7,
  parameter int DATA_LEN        = 8,
  parameter int SETUP_SDA_START = 2,
  parameter int T_HOLD_START    = 2,
  parameter int T_HIGH          = 4,
  parameter int T_LOW           = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state_master,
  input  logic       rst_count,
  input  logic       rst_count_2,
  inout  wire        scl,
  output logic [6:0] count_ctrl,
  output logic [3:0] count,
  output logic       wait_for_sync,
  output logic       add_sent,
  output logic       data_sent,
  output logic       data_received
);

  typedef enum logic [3:0] {
    S_IDLE           = 4'd0,
    S_READY          = 4'd1,
    S_SEND_ADDRESS   = 4'd2,
    S_CHECK_ACK_ADDR = 4'd3,
    S_WRITE_DATA     = 4'd4,
    S_CHECK_ACK_DATA = 4'd5,
    S_READ_DATA      = 4'd6,
    S_SEND_ACK       = 4'd7,
    S_STOP           = 4'd8
  } state_e;

  if ((ADDR_LEN + 1 > 16) ||
      (T_LOW + T_HIGH + SETUP_SDA_START + T_HOLD_START > 127)) begin : g_bad_params
    $error("scl_generate: counter width rule violated by parameters");
  end

  localparam logic [6:0] CC_BIT_END   = 7'(T_LOW + T_HIGH - 1);
  localparam logic [6:0] CC_START_END = 7'(SETUP_SDA_START + T_HOLD_START - 1);
  localparam logic [6:0] CC_LOW       = 7'(T_LOW);
  localparam logic [3:0] CNT_ADDR_END = 4'(ADDR_LEN);
  localparam logic [3:0] CNT_DATA_END = 4'(DATA_LEN - 1);

  logic       scl_low, scl_low_next;
  logic       stop_rel, stop_rel_next;
  logic [6:0] cc_next, wrap_at;
  logic [3:0] cnt_next;
  logic       is_ready, is_bit, is_byte, stretch_hold;

  assign scl = scl_low ? 1'b0 : 1'bz;

`ifdef SCL_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_sync <= 2'b11;
    else        scl_sync <= {scl_sync[0], scl};
  end

  // Released by us but still seen low: a slave is stretching, so park at the start of the high phase.
  assign stretch_hold = !scl_low && !scl_sync[1] && (count_ctrl == CC_LOW);
`else
  assign stretch_hold = 1'b0;
`endif

  always_comb begin
    is_ready      = (state_master == S_READY);
    is_bit        = (state_master >= S_SEND_ADDRESS) && (state_master <= S_STOP);
    is_byte       = (state_master == S_SEND_ADDRESS) || (state_master == S_WRITE_DATA) ||
                    (state_master == S_READ_DATA);
    wrap_at       = is_ready ? CC_START_END : CC_BIT_END;

    cc_next = 7'd0;
    if (!rst_count && (is_ready || is_bit)) begin
      if (stretch_hold)            cc_next = count_ctrl;
      else if (count_ctrl < wrap_at) cc_next = count_ctrl + 7'd1;
    end

    cnt_next = count;
    if (rst_count_2)                                  cnt_next = 4'd0;
    else if (is_byte && (count_ctrl == CC_BIT_END))   cnt_next = count + 4'd1;

    // SCL is derived from the next counter value so pin and counter change on the same edge.
    stop_rel_next = 1'b0;
    scl_low_next  = 1'b0;
    if (is_ready) begin
      scl_low_next = (count_ctrl == CC_START_END);
    end else if (state_master == S_STOP) begin
      stop_rel_next = stop_rel || (cc_next >= CC_LOW);
      scl_low_next  = !stop_rel_next;
    end else if (is_bit) begin
      scl_low_next = (cc_next < CC_LOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_ctrl <= 7'd0;
      count      <= 4'd0;
      scl_low    <= 1'b0;
      stop_rel   <= 1'b0;
    end else begin
      count_ctrl <= cc_next;
      count      <= cnt_next;
      scl_low    <= scl_low_next;
      stop_rel   <= stop_rel_next;
    end
  end

  assign wait_for_sync = (state_master == S_READY) && (count_ctrl == CC_START_END);
  assign add_sent      = (state_master == S_SEND_ADDRESS) && (count == CNT_ADDR_END) &&
                         (count_ctrl == CC_BIT_END);
  assign data_sent     = (state_master == S_WRITE_DATA) && (count == CNT_DATA_END) &&
                         (count_ctrl == CC_BIT_END);
  assign data_received = (state_master == S_READ_DATA) && (count == CNT_DATA_END) &&
                         (count_ctrl == CC_BIT_END);

endmodule

// File: doc/scl_generate.md
# scl_generate

Bit-timing engine for the I2C master. Generates the SCL waveform and the per-bit (`count_ctrl`) and per-byte (`count`) counters, and decodes the phase-completion strobes (`wait_for_sync`, `add_sent`, `data_sent`, `data_received`). These strobes feed `sda_generate`. It is steered by that FSM's `state_master`, `rst_count` and `rst_count_2` outputs. It sits directly upstream of `sda_generate` and shares its timing parameters.

## Interface
Parameters:
- `ADDR_LEN`, 7: address bits; the address phase is ADDR_LEN+1 bits including R/W.
- `DATA_LEN`, 8: bits per data byte.
- `SETUP_SDA_START`, 2: clocks from Ready entry to the SDA fall.
- `T_HOLD_START`, 2: clocks SCL stays high after the SDA fall (START hold).
- `T_HIGH`, 4: SCL high clocks per bit.
- `T_LOW`, 6: SCL low clocks per bit.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `state_master`, in, 4: FSM state. Codes: Idle 0, Ready 1, Send_Address 2, Check_ACK_addr 3, Write_Data 4, Check_ACK_data 5, Read_Data 6, Send_ACK 7, Stop 8.
- `rst_count`, in, 1: synchronous clear of `count_ctrl`.
- `rst_count_2`, in, 1: synchronous clear of `count`.
- `scl`, inout, 1: open-drain SCL. Driven 0 or released (z).
- `count_ctrl`, out, 7: clock index within the current bit period.
- `count`, out, 4: bit index within the current byte.
- `wait_for_sync`, out, 1: START complete strobe.
- `add_sent`, `data_sent`, `data_received`, out, 1 each: phase-done strobes.

## Operation
- `count_ctrl` register:
  - `rst_count`=1: next value 0. This has the highest priority.
  - Otherwise it increments. It wraps to 0 after T_LOW+T_HIGH-1.
  - Unknown state codes (9–15): behave as Idle. SCL is released and the counter is held at 0.
- `count` register:
  - `rst_count_2`=1: next value 0.
  - Otherwise it increments when `count_ctrl`==T_LOW+T_HIGH-1 and the state is Send_Address, Write_Data or Read_Data.
  - It holds in every other state.
- SCL drive register `scl_low`:
  - Idle, Ready before the hold expires: released.
  - Send_Address, Check_ACK_addr, Write_Data, Check_ACK_data, Read_Data, Send_ACK: low while `count_ctrl` < T_LOW, released otherwise.
  - Stop: low while `count_ctrl` < T_LOW, then released and held released.
  - `scl_low` is registered from the next `count_ctrl`, so the pin and the counter phase stay aligned.
- Strobes are combinational decodes of registered state and counters. Each is exactly 1 cycle wide.
  - `wait_for_sync` = Ready && `count_ctrl`==SETUP_SDA_START+T_HOLD_START-1.
  - `add_sent` = Send_Address && `count`==ADDR_LEN && `count_ctrl`==T_LOW+T_HIGH-1.
  - `data_sent` = Write_Data && `count`==DATA_LEN-1 && `count_ctrl`==T_LOW+T_HIGH-1.
  - `data_received` = Read_Data && `count`==DATA_LEN-1 && `count_ctrl`==T_LOW+T_HIGH-1.
- Width rule: ADDR_LEN+1 ≤ 16 and T_LOW+T_HIGH+SETUP_SDA_START+T_HOLD_START ≤ 127. Violating either is an elaboration error.

## Timing
- Reset values: `scl` released, `count_ctrl`=0, `count`=0, all strobes 0.
- Bit period is T_LOW+T_HIGH clocks (10 by default). The SDA update point at `count_ctrl`==T_LOW-SETUP_SDA-1 falls inside the low phase.
- START sequence:
  - Ready is entered with `count_ctrl`=0.
  - SDA falls at `count_ctrl`=1.
  - `wait_for_sync` is high at `count_ctrl`=3.
  - Next cycle: `count_ctrl`=0 and SCL low.
- Strobes coincide with the `count_ctrl` wrap, so the FSM changes state on the same edge the counter wraps. No dead cycle.
- Simultaneous `rst_count` with a wrap: result is 0 either way, no conflict. Simultaneous `rst_count_2` with a `count` increment: the clear wins.
- Reset asserted mid-byte: all outputs return to reset values immediately (asynchronously). SCL is released within the same cycle.

## Configuration
- `SCL_STRETCH_EN` defined:
  - The SCL pin is sampled through a 2-flop synchronizer.
  - When SCL is released but the synchronized value reads 0, `count_ctrl` holds at T_LOW.
  - Effect: the high phase starts from the observed rise, so the nominal high phase lengthens by 2 clocks and a slave may stretch the clock indefinitely.
  - `rst_count` still clears the counter.
- Undefined: there is no synchronizer and no pin sampling. Timing is fully free-running as described above.

## Test plan
- Reset held with `state_master`=Idle → `scl`=1, `count_ctrl`=0, `count`=0, all strobes 0. Assert `rst_n` low mid-bit → the same values immediately.
- Ready entered → `wait_for_sync` is a single pulse 3 clocks after entry. SCL goes low on the next clock.
- Send_Address from `count`=0 → 8 SCL pulses, each low 6 and high 4 clocks. `add_sent` pulses once at `count`=7, `count_ctrl`=9.
- Write_Data then Read_Data bytes → `data_sent` and `data_received` each pulse exactly once per 80 clocks, at `count`=7.
- Stop state → SCL low for 6 clocks, then released and remaining high. Idle → `count_ctrl` held at 0.
- Stretch build (`SCL_STRETCH_EN`): bench holds SCL low for 20 clocks after the master releases it → `count_ctrl` stays at 6 until the synchronized rise, then completes 4 more high clocks. Strobes shift by the stretch length.
